iu_logic_wb: RTL and testbench

Writeback stage directly downstream of the IU logical unit. Accepts each logical-unit result (32-bit result, 4-bit flags {n,z,v,c}, 6-bit op, destination register) through a valid/ready handshake. Buffers up to two results in a skid FIFO and drives them to the register-file write port under a write/acknowledge handshake. Commits the integer condition codes (icc) only for the `cc` forms of the operations.

---
 rtl/iu_logic_wb.sv | 104 ++++++++++
 tb/tb_iu_logic_wb.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/iu_logic_wb.sv
// Writeback stage for the IU logical unit: a two-entry skid FIFO that feeds the register-file
// write port and commits integer condition codes when cc-form results retire.
module iu_logic_wb #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned RD_W  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_result,
  input  logic [3:0]      in_flags,
  input  logic [5:0]      in_op,
  input  logic [RD_W-1:0] in_rd,
  input  logic            flush,
  output logic            wr_en,
  output logic [RD_W-1:0] wr_addr,
  output logic [31:0]     wr_data,
  input  logic            wr_ack,
  output logic [3:0]      icc,
  output logic            icc_upd,
  output logic            retire
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e state_q, state_d;

  logic [31:0]     res_q   [DEPTH];
  logic [3:0]      flags_q [DEPTH];
  logic            cc_q    [DEPTH];
  logic [RD_W-1:0] rd_q    [DEPTH];

  logic       rd_ptr_q, wr_ptr_q;
  logic [3:0] icc_q;
  logic       icc_upd_q, retire_q;

  logic head_valid, head_g0, accept, retire_now;

  assign in_ready   = (state_q != StTwo);
  assign head_valid = (state_q != StEmpty);
  assign head_g0    = (rd_q[rd_ptr_q] == '0);
  assign accept     = in_valid & in_ready & ~flush;
  // %g0 writes are dropped, so such an entry retires without waiting for an ack.
  assign retire_now = head_valid & (head_g0 | wr_ack) & ~flush;

  assign wr_en   = head_valid & ~head_g0;
  assign wr_addr = head_valid ? rd_q[rd_ptr_q] : '0;
  assign wr_data = head_valid ? res_q[rd_ptr_q] : '0;
  assign icc     = icc_q;
  assign icc_upd = icc_upd_q;
  assign retire  = retire_q;

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: if (accept) state_d = StOne;
        StOne: begin
          if (accept && !retire_now)      state_d = StTwo;
          else if (!accept && retire_now) state_d = StEmpty;
        end
        StTwo:   if (retire_now) state_d = StOne;
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StEmpty;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      icc_q     <= 4'b0000;
      icc_upd_q <= 1'b0;
      retire_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      icc_upd_q <= retire_now & cc_q[rd_ptr_q];
      retire_q  <= retire_now;
      if (retire_now && cc_q[rd_ptr_q]) icc_q <= flags_q[rd_ptr_q];
      if (flush) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
      end else begin
        if (accept)     wr_ptr_q <= ~wr_ptr_q;
        if (retire_now) rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  // Payload storage needs no reset: outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    if (accept) begin
      res_q[wr_ptr_q]   <= in_result;
      flags_q[wr_ptr_q] <= in_flags;
      cc_q[wr_ptr_q]    <= in_op[4];
      rd_q[wr_ptr_q]    <= in_rd;
    end
  end

endmodule

// File: tb/tb_iu_logic_wb.sv
// Scoreboard bench for iu_logic_wb: a queue-based model predicts retirements and icc commits,
// a separate monitor checks each retire pulse against the expected record.
module tb_iu_logic_wb;
  localparam int unsigned RD_W = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     in_result = '0;
  logic [3:0]      in_flags = '0;
  logic [5:0]      in_op = '0;
  logic [RD_W-1:0] in_rd = '0;
  logic            flush = 1'b0;
  logic            wr_en;
  logic [RD_W-1:0] wr_addr;
  logic [31:0]     wr_data;
  logic            wr_ack = 1'b0;
  logic [3:0]      icc;
  logic            icc_upd;
  logic            retire;

  iu_logic_wb #(.DEPTH(2), .RD_W(RD_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_flags(in_flags), .in_op(in_op), .in_rd(in_rd),
    .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .icc(icc), .icc_upd(icc_upd), .retire(retire)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]     res;
    logic [3:0]      fl;
    logic            cc;
    logic [RD_W-1:0] rd;
  } ent_t;

  typedef struct {
    logic       cc;
    logic [3:0] icc;
  } ret_t;

  ent_t       mq[$];   // model buffer contents, head first
  ret_t       sb[$];   // expected retirements in order
  logic [3:0] icc_m = 4'b0000;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: check outputs against model, drive inputs, then advance the model to the next edge.
  task automatic step(input logic v, input logic [31:0] res, input logic [3:0] fl,
                      input logic [5:0] op, input logic [RD_W-1:0] rd, input logic ack,
                      input logic fs);
    int   sz0;
    logic ret, acc;
    ent_t e;
    @(negedge clk);
    chk("in_ready", in_ready, (mq.size() < 2));
    chk("wr_en", wr_en, (mq.size() > 0 && mq[0].rd != 0));
    if (mq.size() > 0 && mq[0].rd != 0) begin
      chk("wr_addr", wr_addr, mq[0].rd);
      chk("wr_data", wr_data, mq[0].res);
    end
    chk("icc", icc, icc_m);
    in_valid = v; in_result = res; in_flags = fl; in_op = op; in_rd = rd;
    wr_ack = ack; flush = fs;
    sz0 = mq.size();
    ret = !fs && sz0 > 0 && (mq[0].rd == 0 || ack);
    acc = !fs && v && sz0 < 2;
    if (ret) begin
      e = mq.pop_front();
      if (e.cc) icc_m = e.fl;
      sb.push_back('{cc: e.cc, icc: icc_m});
    end
    if (acc) mq.push_back('{res: res, fl: fl, cc: op[4], rd: rd});
    if (fs) mq.delete();
  endtask

  task automatic idle(input logic ack);
    step(1'b0, 32'h0, 4'h0, 6'h0, '0, ack, 1'b0);
  endtask

  // Monitor: every retire pulse must match the oldest predicted retirement.
  initial begin
    ret_t r;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (retire) begin
          if (sb.size() == 0) begin
            chk("retire_unexpected", 1'b1, 1'b0);
          end else begin
            r = sb.pop_front();
            chk("icc_upd_on_retire", icc_upd, r.cc);
            chk("icc_after_retire", icc, r.icc);
          end
        end else begin
          chk("icc_upd_idle", icc_upd, 1'b0);
        end
      end
    end
  end

  initial begin
    logic [RD_W-1:0] rd;
    // Reset state.
    #12;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_icc", icc, 4'b0000);
    chk("rst_retire", {icc_upd, retire}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    // ANDcc to r3.
    step(1'b1, 32'h0, 4'b0100, 6'b010001, 5'd3, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    chk("andcc_icc", icc, 4'b0100);
    // Non-cc OR to r5 leaves icc.
    step(1'b1, 32'h8000_0001, 4'b1000, 6'b000010, 5'd5, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    chk("or_icc_kept", icc, 4'b0100);
    // Backpressure: third valid must stall.
    for (int i = 0; i < 3; i++)
      step(1'b1, $urandom, 4'($urandom), 6'b010010, 5'(i + 7), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b1);
    // %g0 destination.
    step(1'b1, 32'h1234_5678, 4'b1000, 6'b010011, 5'd0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("g0_icc", icc, 4'b1000);
    // Flush with two entries buffered and ack high.
    step(1'b1, 32'hAAAA_0001, 4'b0001, 6'b010001, 5'd9, 1'b0, 1'b0);
    step(1'b1, 32'hAAAA_0002, 4'b0010, 6'b010001, 5'd10, 1'b0, 1'b0);
    step(1'b1, 32'hAAAA_0003, 4'b0011, 6'b010001, 5'd11, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("flush_icc_kept", icc, 4'b1000);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      rd = ($urandom_range(0, 7) == 0) ? '0 : RD_W'($urandom_range(1, 31));
      step(1'($urandom_range(0, 3) != 0), $urandom, 4'($urandom), 6'($urandom), rd,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
    end

    // Asynchronous reset between edges with the buffer full.
    step(1'b1, 32'h1, 4'b1111, 6'b010001, 5'd1, 1'b0, 1'b0);
    step(1'b1, 32'h2, 4'b1111, 6'b010001, 5'd2, 1'b0, 1'b0);
    step(1'b1, 32'h3, 4'b1111, 6'b010001, 5'd3, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    mq.delete();
    sb.delete();
    icc_m = 4'b0000;
    #1;
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_wr_en", wr_en, 1'b0);
    chk("arst_wr_addr", wr_addr, 0);
    chk("arst_wr_data", wr_data, 0);
    chk("arst_icc", icc, 4'b0000);
    chk("arst_pulses", {icc_upd, retire}, 2'b00);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Post-reset traffic and drain.
    for (int i = 0; i < 50; i++) begin
      rd = ($urandom_range(0, 5) == 0) ? '0 : RD_W'($urandom_range(1, 31));
      step(1'($urandom), $urandom, 4'($urandom), 6'($urandom), rd, 1'($urandom), 1'b0);
    end
    for (int i = 0; i < 6; i++) idle(1'b1);
    @(negedge clk);
    #1;
    chk("drain_model_empty", mq.size(), 0);
    chk("drain_sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
